// File: rtl/vram_write_ctrl.sv
// Arbitrates the shared text-mode VRAM port between scan-out reads, queued host
// writes and a full-screen clear fill. Scan-out always wins the port.
module vram_write_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int COLS       = 80,
    parameter int ROWS       = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_active,
    input  logic [11:0] scan_addr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_char,
    input  logic [7:0]  wr_colr,
    input  logic [1:0]  wr_mask,
    input  logic        clr_start,
    input  logic [7:0]  clr_char,
    input  logic [7:0]  clr_colr,
    output logic        busy,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_char,
    output logic [7:0]  ram_colr,
    output logic        wren_ms,
    output logic        wren_mc,
    output logic        drop_err,
    output logic [1:0]  dbg_state
);

    localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_W  = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]      COLS_W   = 8'(COLS);
    localparam logic [5:0]      ROWS_W   = 6'(ROWS);
    localparam logic [6:0]      COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]      ROW_LAST = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  chr;
        logic [7:0]  colr;
        logic [1:0]  mask;
    } entry_t;

    state_t        state, state_nxt;
    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, fifo_empty;
    logic          push, pop, clr_accept, clear_step, clr_last, head_oor;
    logic [6:0]    clr_col;
    logic [4:0]    clr_row;
    logic [7:0]    fill_char, fill_colr;

    // Host handshake: an entry is taken on any rising edge where wr_valid and
    // wr_ready are both 1; wr_ready is simply "queue not full" and never waits
    // on wr_valid, so the host may hold wr_valid until it sees wr_ready.
    assign fifo_full  = (count == DEPTH_W);
    assign fifo_empty = (count == '0);
    assign wr_ready   = ~fifo_full;
    assign push       = wr_valid & wr_ready;

    assign busy       = (state == ST_CLEAR);
    assign dbg_state  = state;
    assign clr_accept = clr_start & ~busy;
    assign clear_step = busy & ~scan_active;
    assign clr_last   = (clr_col == COL_LAST) && (clr_row == ROW_LAST);

    // Popping is allowed in IDLE as well so a write into an empty queue
    // reaches the RAM on the very next free edge.
    assign pop      = ~busy & ~fifo_empty & ~scan_active & ~clr_accept;
    assign head     = fifo_mem[rd_ptr];
    assign head_oor = ({1'b0, head.addr[6:0]} >= COLS_W) ||
                      ({1'b0, head.addr[11:7]} >= ROWS_W);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: wr_addr, chr: wr_char, colr: wr_colr, mask: wr_mask};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clr_accept)       state_nxt = ST_CLEAR;
                else if (!fifo_empty) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (clr_accept)       state_nxt = ST_CLEAR;
                else if (fifo_empty)  state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clear_step && clr_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Raster position and fill data of the clear; data is latched at start
    // so the host may change clr_char/clr_colr during the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_col   <= '0;
            clr_row   <= '0;
            fill_char <= '0;
            fill_colr <= '0;
        end else if (clr_accept) begin
            clr_col   <= '0;
            clr_row   <= '0;
            fill_char <= clr_char;
            fill_colr <= clr_colr;
        end else if (clear_step) begin
            if (clr_col == COL_LAST) begin
                clr_col <= '0;
                clr_row <= clr_row + 5'd1;
            end else begin
                clr_col <= clr_col + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_char <= '0;
            ram_colr <= '0;
            wren_ms  <= 1'b0;
            wren_mc  <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            wren_ms  <= 1'b0;
            wren_mc  <= 1'b0;
            drop_err <= 1'b0;
            if (scan_active) begin
                ram_addr <= scan_addr;
            end else if (clear_step) begin
                ram_addr <= {clr_row, clr_col};
                ram_char <= fill_char;
                ram_colr <= fill_colr;
                wren_ms  <= 1'b1;
                wren_mc  <= 1'b1;
            end else if (pop) begin
                ram_addr <= head.addr;
                ram_char <= head.chr;
                ram_colr <= head.colr;
                if (head_oor) begin
                    drop_err <= 1'b1;
                end else begin
                    wren_ms <= head.mask[0];
                    wren_mc <= head.mask[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Directed bench for vram_write_ctrl: queued writes, full-queue back-pressure,
// out-of-range drops, full-screen clear and reset abort.
module tb_vram_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_active;
    logic [11:0] scan_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [7:0]  wr_char;
    logic [7:0]  wr_colr;
    logic [1:0]  wr_mask;
    logic        clr_start;
    logic [7:0]  clr_char;
    logic [7:0]  clr_colr;
    logic        busy;
    logic [11:0] ram_addr;
    logic [7:0]  ram_char;
    logic [7:0]  ram_colr;
    logic        wren_ms;
    logic        wren_mc;
    logic        drop_err;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [29:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          mon_cnt = 0;

    vram_write_ctrl #(.FIFO_DEPTH(4), .COLS(80), .ROWS(25)) dut (
        .clk(clk), .rst_n(rst_n), .scan_active(scan_active), .scan_addr(scan_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_char(wr_char), .wr_colr(wr_colr), .wr_mask(wr_mask),
        .clr_start(clr_start), .clr_char(clr_char), .clr_colr(clr_colr),
        .busy(busy), .ram_addr(ram_addr), .ram_char(ram_char), .ram_colr(ram_colr),
        .wren_ms(wren_ms), .wren_mc(wren_mc), .drop_err(drop_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [11:0] a, input logic [7:0] c,
                             input logic [7:0] k, input logic [1:0] m);
        wr_addr = a;
        wr_char = c;
        wr_colr = k;
        wr_mask = m;
    endtask

    // clear-fill monitor: every write while enabled must be the next raster cell
    always @(negedge clk) begin
        logic [11:0] exp_addr;
        int row, col;
        if (mon_en && (wren_ms || wren_mc)) begin
            row      = mon_cnt / 80;
            col      = mon_cnt % 80;
            exp_addr = {row[4:0], col[6:0]};
            check("clr_cell", {2'b00, ram_addr, ram_char, ram_colr, wren_ms, wren_mc},
                  {2'b00, exp_addr, 8'h20, 8'h07, 2'b11});
            mon_cnt++;
        end
    end

    logic [11:0] tbl_addr [5] = '{12'h000, 12'h001, 12'h080, 12'hC4F, 12'h7FF};
    logic [1:0]  tbl_mask [5] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd3};

    initial begin
        int cyc;
        int wcnt;
        logic [7:0] ch, co;

        rst_n = 1'b0; scan_active = 1'b0; scan_addr = '0; wr_valid = 1'b0;
        set_entry(12'h0, 8'h0, 8'h0, 2'd0);
        clr_start = 1'b0; clr_char = '0; clr_colr = '0;
        repeat (3) tick();
        check("rst_outputs", {2'b00, ram_addr, ram_char, ram_colr, wren_ms, wren_mc}, 32'h0);
        check("rst_flags", {busy, drop_err, wr_ready, dbg_state}, {1'b0, 1'b0, 1'b1, 2'd0});
        rst_n = 1'b1;
        tick();

        // single write latency
        set_entry(12'h105, 8'h41, 8'h1F, 2'd3);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("lat_push_edge_wren", {wren_ms, wren_mc}, 2'b00);
        tick();
        check("lat_write", {2'b00, ram_addr, ram_char, ram_colr, wren_ms, wren_mc},
              {2'b00, 12'h105, 8'h41, 8'h1F, 2'b11});
        tick();
        check("lat_one_cycle", {wren_ms, wren_mc}, 2'b00);
        check("idle_hold_addr", ram_addr, 12'h105);

        // fill the queue while scan-out owns the port
        scan_active = 1'b1;
        scan_addr   = 12'h123;
        for (int i = 0; i < 5; i++) begin
            check("full_ready", wr_ready, (i < 4) ? 1'b1 : 1'b0);
            set_entry(tbl_addr[i], 8'h10 + 8'(i), 8'hA0 + 8'(i), tbl_mask[i]);
            wr_valid = 1'b1;
            if (i < 4) exp_q.push_back({tbl_addr[i], 8'h10 + 8'(i), 8'hA0 + 8'(i), tbl_mask[i]});
            tick();
        end
        wr_valid = 1'b0;
        check("scan_addr_load", ram_addr, 12'h123);
        check("scan_no_wren", {wren_ms, wren_mc, wr_ready}, 3'b000);
        scan_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fifo_order", {2'b00, ram_addr, ram_char, ram_colr, wren_mc, wren_ms},
                  {2'b00, exp_q.pop_front()});
        end
        tick();
        check("fifo_no_fifth", {wren_ms, wren_mc, wr_ready}, 3'b001);

        // out-of-range entries are dropped, neighbours still written
        set_entry(12'h050, 8'h11, 8'h22, 2'd3);
        wr_valid = 1'b1;
        tick();
        set_entry(12'h201, 8'h55, 8'h66, 2'd3);
        tick();
        check("drop_col", {drop_err, wren_ms, wren_mc}, 3'b100);
        set_entry(12'hC80, 8'h33, 8'h44, 2'd3);
        tick();
        wr_valid = 1'b0;
        check("after_drop_write", {1'b0, drop_err, ram_addr, ram_char, ram_colr, wren_ms, wren_mc},
              {1'b0, 1'b0, 12'h201, 8'h55, 8'h66, 2'b11});
        tick();
        check("drop_row", {drop_err, wren_ms, wren_mc}, 3'b100);
        tick();
        check("drop_one_cycle", {drop_err, wren_ms, wren_mc}, 3'b000);

        // full-screen clear with scan-out taking every other cycle
        clr_char = 8'h20; clr_colr = 8'h07; clr_start = 1'b1;
        tick();
        clr_start = 1'b0; clr_char = 8'hFF; clr_colr = 8'hFF;
        check("clr_busy_rise", busy, 1'b1);
        set_entry(12'h000, 8'h99, 8'h88, 2'd1);
        scan_addr = 12'h3A5;
        mon_en = 1'b1;
        cyc = 0;
        while (busy && cyc < 6000) begin
            scan_active = cyc[0];
            wr_valid    = (cyc == 500);
            clr_start   = (cyc == 1001);
            if (cyc == 1001) begin
                clr_char = 8'hAA;
                clr_colr = 8'h55;
            end
            tick();
            cyc++;
        end
        clr_start = 1'b0; wr_valid = 1'b0;
        check("clr_done_in_time", busy, 1'b0);
        check("clr_last_cell", {wren_ms, wren_mc, ram_addr}, {2'b11, 12'hC4F});
        scan_active = 1'b1;
        tick();
        mon_en = 1'b0;
        check("clr_cell_count", mon_cnt, 2000);
        scan_active = 1'b0;
        tick();
        check("clr_host_override", {2'b00, ram_addr, ram_char, ram_colr, wren_ms, wren_mc},
              {2'b00, 12'h000, 8'h99, 8'h88, 2'b10});

        // reset in the middle of a clear with a host write pending
        clr_char = 8'h41; clr_colr = 8'h02; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr2_busy", busy, 1'b1);
        set_entry(12'h300, 8'h77, 8'h66, 2'd3);
        for (int i = 0; i < 10; i++) begin
            wr_valid = (i == 3);
            tick();
        end
        wr_valid = 1'b0;
        check("clr2_writing", {wren_ms, wren_mc, ram_char}, {2'b11, 8'h41});
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {2'b00, ram_addr, ram_char, ram_colr, wren_ms, wren_mc}, 32'h0);
        check("async_rst_flags", {busy, drop_err, wr_ready, dbg_state}, {1'b0, 1'b0, 1'b1, 2'd0});
        set_entry(12'h3FF, 8'hEE, 8'hDD, 2'd3);
        wr_valid = 1'b1; clr_start = 1'b1;
        repeat (2) tick();
        wr_valid = 1'b0; clr_start = 1'b0;
        tick();
        rst_n = 1'b1;
        wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wren_ms || wren_mc || busy || drop_err) wcnt++;
        end
        check("post_rst_quiet", wcnt, 0);
        set_entry(12'h010, 8'h3C, 8'h5A, 2'd3);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        ch = ram_char;
        co = ram_colr;
        check("post_rst_fifo_empty", {2'b00, ram_addr, ch, co, wren_ms, wren_mc},
              {2'b00, 12'h010, 8'h3C, 8'h5A, 2'b11});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_write_ctrl.md
VRAM_WRITE_CTRL -- requirements
Module: vram_write_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, host write-queue depth (power of two, >=2).
REQ-002 SHALL have parameter COLS, default 80, text columns per row.
REQ-003 SHALL have parameter ROWS, default 25, text rows per screen.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port scan_active  in  1  scan-out needs the RAM port this cycle.
REQ-007 SHALL have port scan_addr  in  12  scan-out read address: [6:0] column, [11:7] row.
REQ-008 SHALL have port wr_valid  in  1  host write request.
REQ-009 SHALL have port wr_ready  out  1  queue can accept; equals not-full, combinational.
REQ-010 SHALL have port wr_addr  in  12  host target address, same packing as scan_addr.
REQ-011 SHALL have port wr_char  in  8  character code to write.
REQ-012 SHALL have port wr_colr  in  8  colour attribute to write.
REQ-013 SHALL have port wr_mask  in  2  bit0 write char RAM, bit1 write colour RAM.
REQ-014 SHALL have port clr_start  in  1  one-cycle pulse; starts a full-screen fill.
REQ-015 SHALL have port clr_char  in  8  fill character, sampled on accepted clr_start.
REQ-016 SHALL have port clr_colr  in  8  fill colour, sampled on accepted clr_start.
REQ-017 SHALL have port busy  out  1  clear fill in progress.
REQ-018 SHALL have port ram_addr  out  12  shared RAM address, registered.
REQ-019 SHALL have port ram_char  out  8  char RAM write data, registered.
REQ-020 SHALL have port ram_colr  out  8  colour RAM write data, registered.
REQ-021 SHALL have port wren_ms  out  1  char RAM write enable, registered.
REQ-022 SHALL have port wren_mc  out  1  colour RAM write enable, registered.
REQ-023 SHALL have port drop_err  out  1  one-cycle pulse: queued write discarded, address out of range.

Function
REQ-024 Push SHALL occur on an edge with wr_valid=1 and wr_ready=1; {addr,char,colr,mask} stored in FIFO order.
REQ-025 Each edge with scan_active=1 SHALL load ram_addr<=scan_addr, wren_ms<=0, wren_mc<=0; no pop, no clear step (one-cycle read latency is owned by the timing block).
REQ-026 FSM states: IDLE, DRAIN, CLEAR. IDLE->DRAIN when FIFO non-empty; DRAIN->IDLE when FIFO empties; IDLE/DRAIN->CLEAR on clr_start; CLEAR->IDLE after last cell written.
REQ-027 In DRAIN, each edge with scan_active=0 SHALL pop the head entry, load ram_addr/ram_char/ram_colr from it, and set wren_ms=mask[0], wren_mc=mask[1].
REQ-028 A popped entry with column>=COLS or row>=ROWS SHALL produce wren_ms=wren_mc=0 and drop_err=1 for one cycle.
REQ-029 Write latency: entry pushed at edge N into an empty FIFO with scan_active=0 at edge N+1 SHALL show wren high from edge N+1 to edge N+2.
REQ-030 clr_start while busy=1 SHALL be ignored; in DRAIN it preempts draining, and the FIFO contents stay queued.
REQ-031 CLEAR SHALL write row 0..ROWS-1, column 0..COLS-1 in raster order, one cell per edge with scan_active=0, wren_ms=wren_mc=1, data clr_char/clr_colr; 2000 cells at default.
REQ-032 busy SHALL be 1 from the edge after accepted clr_start through the edge writing the last cell.
REQ-033 During CLEAR, pushes SHALL still be accepted; the FIFO SHALL drain only after CLEAR ends, so host writes override the fill.
REQ-034 Push on a full FIFO SHALL not occur; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-035 Cycles with scan_active=0 and no work SHALL hold ram_addr, and SHALL drive both wren outputs 0.

Reset
REQ-036 rst_n low SHALL asynchronously force: FIFO empty, state IDLE, busy=0, ram_addr=0, ram_char=0, ram_colr=0, wren_ms=0, wren_mc=0, drop_err=0.
REQ-037 Pushes and clr_start while rst_n low SHALL be ignored; reset during CLEAR aborts the fill with no further writes.

Verification
REQ-038 scan_active=0, push addr {row 2, col 5}=0x105, char 0x41, colr 0x1F, mask 3 -> next edge ram_addr=0x105, wren_ms=wren_mc=1 for one cycle.
REQ-039 Push 5 entries back-to-back with scan_active=1 -> wr_ready=0 after 4th; release scan_active -> 4 writes in push order on 4 consecutive cycles.
REQ-040 Push col 80 row 0, mask 3 -> drop_err=1 one cycle, no wren; next entry still written.
REQ-041 clr_start with 0x20/0x07, scan_active toggling 50% -> exactly 2000 writes, last at 0xC4F, busy falls after it; second clr_start mid-fill ignored.
REQ-042 Push during CLEAR then assert rst_n low mid-fill -> all outputs 0 immediately, busy=0, FIFO empty, no writes after release.
